// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage: MULT, MULTU, DIV, DIVU
// over WIDTH-bit operands, with results held in HI/LO until the next completion.
//
// Ports:
//   CLK, RST       clock, asynchronous active-high reset
//   start, op      request (sampled only while ready); 00 MULT 01 MULTU 10 DIV 11 DIVU
//   portA, portB   multiplicand/dividend, multiplier/divisor (sampled with start)
//   flush          synchronous abort of the in-flight operation
//   ready, busy    idle / not idle, for the hazard unit
//   done           one-cycle completion pulse
//   divzero        last completed op was a divide by zero
//   hi, lo         HI/LO result registers
//
// Build option: define MULDIV_EARLY_OUT_EN to end a multiply as soon as the
// remaining multiplier bits are zero (results identical, divide unaffected).
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] portA,
   input  logic [WIDTH-1:0] portB,
   input  logic             flush,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic             divzero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_RUN,
      S_FIX,
      S_DONE
   } state_t;

   state_t             state;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   a_raw;
   logic [WIDTH-1:0]   b_raw;
   // b: multiplier (shifted right) or divisor
   logic [WIDTH-1:0]   b;
   // acc: product accumulator, or remainder in the low half
   logic [2*WIDTH-1:0] acc;
   // sh: shifted multiplicand, or dividend/quotient shifter in the low half
   logic [2*WIDTH-1:0] sh;
   logic [CW-1:0]      cnt;
   logic               neg_p;
   logic               neg_r;

   logic               is_mul;
   logic               sgn;
   logic               sa;
   logic               sb;
   logic [WIDTH-1:0]   a_abs;
   logic [WIDTH-1:0]   b_abs;
   logic [2*WIDTH-1:0] mul_sum;
   logic [WIDTH:0]     div_r1;
   logic [WIDTH:0]     div_sub;
   logic               div_ge;
   logic               early;
   logic               last_step;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;

   assign ready = (state == S_IDLE);
   assign busy  = ~ready;

   always_comb begin
      is_mul  = ~op_q[1];
      sgn     = ~op_q[0];
      sa      = sgn & a_raw[WIDTH-1];
      sb      = sgn & b_raw[WIDTH-1];
      a_abs   = sa ? -a_raw : a_raw;
      b_abs   = sb ? -b_raw : b_raw;
      mul_sum = b[0] ? (acc + sh) : acc;
      div_r1  = {acc[WIDTH-1:0], sh[WIDTH-1]};
      div_sub = div_r1 - {1'b0, b};
      // no borrow out of the trial subtraction means r1 >= divisor
      div_ge  = ~div_sub[WIDTH];
`ifdef MULDIV_EARLY_OUT_EN
      early   = is_mul && (b[WIDTH-1:1] == '0);
`else
      early   = 1'b0;
`endif
      last_step = (cnt == LAST) | early;
      prod    = neg_p ? -acc : acc;
      quo     = neg_p ? -sh[WIDTH-1:0] : sh[WIDTH-1:0];
      rem     = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= S_IDLE;
         op_q    <= '0;
         a_raw   <= '0;
         b_raw   <= '0;
         b       <= '0;
         acc     <= '0;
         sh      <= '0;
         cnt     <= '0;
         neg_p   <= 1'b0;
         neg_r   <= 1'b0;
         done    <= 1'b0;
         divzero <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start && !flush) begin
                  op_q  <= op;
                  a_raw <= portA;
                  b_raw <= portB;
                  state <= S_PREP;
               end
            end
            S_PREP: begin
               if (flush) begin
                  state <= S_IDLE;
               end else if (!is_mul && (b_raw == '0)) begin
                  lo      <= '1;
                  hi      <= a_raw;
                  divzero <= 1'b1;
                  done    <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  acc   <= '0;
                  sh    <= {{WIDTH{1'b0}}, a_abs};
                  b     <= b_abs;
                  cnt   <= '0;
                  neg_p <= sa ^ sb;
                  neg_r <= sa;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               if (flush) begin
                  state <= S_IDLE;
               end else begin
                  if (is_mul) begin
                     acc <= mul_sum;
                     sh  <= sh << 1;
                     b   <= b >> 1;
                  end else begin
                     acc[WIDTH-1:0] <= div_ge ? div_sub[WIDTH-1:0]
                                              : div_r1[WIDTH-1:0];
                     sh[WIDTH-1:0]  <= {sh[WIDTH-2:0], div_ge};
                  end
                  cnt <= cnt + 1'b1;
                  if (last_step) state <= S_FIX;
               end
            end
            S_FIX: begin
               if (flush) begin
                  state <= S_IDLE;
               end else begin
                  if (is_mul) begin
                     {hi, lo} <= prod;
                  end else begin
                     lo <= quo;
                     hi <= rem;
                  end
                  divzero <= 1'b0;
                  done    <= 1'b1;
                  state   <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table for results and latency,
// plus hand sequences for flush, ignored start and asynchronous reset.
module tb_muldiv_unit;

   localparam int W = 32;

   logic         CLK = 1'b0;
   logic         RST;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] portA;
   logic [W-1:0] portB;
   logic         flush;
   logic         ready;
   logic         busy;
   logic         done;
   logic         divzero;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   muldiv_unit #(.WIDTH(W)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .start   (start),
      .op      (op),
      .portA   (portA),
      .portB   (portB),
      .flush   (flush),
      .ready   (ready),
      .busy    (busy),
      .done    (done),
      .divzero (divzero),
      .hi      (hi),
      .lo      (lo)
   );

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
   } vec_t;

   localparam int NV = 15;
   vec_t v [NV];

   task automatic chk(input string name, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b);
      @(negedge CLK);
      op    = o;
      portA = a;
      portB = b;
      start = 1'b1;
      @(posedge CLK);
      #1 start = 1'b0;
   endtask

   // called in cycle 1; returns the cycle in which done is seen
   task automatic wait_done(output int cyc, output bit got);
      cyc = 1;
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge CLK);
         if (done) begin
            got = 1'b1;
            break;
         end
         @(posedge CLK);
         cyc++;
      end
   endtask

   task automatic count_done(input int ncyc, output int nd);
      nd = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge CLK);
         if (done) nd++;
      end
   endtask

   function automatic int exp_cyc(input logic [1:0] o, input logic [W-1:0] b);
      if (o[1]) return (b == '0) ? 2 : W + 3;
`ifdef MULDIV_EARLY_OUT_EN
      begin
         logic [W-1:0] m;
         int p;
         m = (o == 2'b00 && b[W-1]) ? -b : b;
         p = 0;
         for (int i = 0; i < W; i++) if (m[i]) p = i;
         return p + 4;
      end
`else
      return W + 3;
`endif
   endfunction

   initial begin
      int cyc;
      bit got;
      int nd;
      int first;

      v[0]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
      v[1]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      v[2]  = '{2'b11, 32'h0000000A, 32'h00000000, 32'h0000000A, 32'hFFFFFFFF, 1'b1};
      v[3]  = '{2'b01, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, 1'b0};
      v[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      v[5]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
      v[6]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
      v[7]  = '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
      v[8]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
      v[9]  = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
      v[10] = '{2'b00, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
      v[11] = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
      v[12] = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
      v[13] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
      v[14] = '{2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};

      RST   = 1'b1;
      start = 1'b0;
      flush = 1'b0;
      op    = 2'b00;
      portA = '0;
      portB = '0;
      #1;
      chk("rst ready", W'(ready), 1);
      chk("rst busy", W'(busy), 0);
      chk("rst done", W'(done), 0);
      chk("rst divzero", W'(divzero), 0);
      chk("rst hi", hi, 0);
      chk("rst lo", lo, 0);
      repeat (2) @(negedge CLK);
      RST = 1'b0;

      for (int i = 0; i < NV; i++) begin
         issue(v[i].op, v[i].a, v[i].b);
         wait_done(cyc, got);
         chk($sformatf("v%0d done", i), W'(got), 1);
         chk($sformatf("v%0d cycle", i), W'(cyc), W'(exp_cyc(v[i].op, v[i].b)));
         chk($sformatf("v%0d hi", i), hi, v[i].hi);
         chk($sformatf("v%0d lo", i), lo, v[i].lo);
         chk($sformatf("v%0d divzero", i), W'(divzero), W'(v[i].dz));
         @(posedge CLK);
         #1;
         chk($sformatf("v%0d ready after", i), W'(ready), 1);
      end

      // flush mid-RUN
      issue(2'b01, 32'd5, 32'd5);
      wait_done(cyc, got);
      chk("5x5 done", W'(got), 1);
      chk("5x5 lo", lo, 32'h19);
      issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
      repeat (9) @(posedge CLK);
      @(negedge CLK);
      flush = 1'b1;
      @(posedge CLK);
      #1 flush = 1'b0;
      chk("flush ready c11", W'(ready), 1);
      chk("flush busy c11", W'(busy), 0);
      count_done(45, nd);
      chk("flush no done", W'(nd), 0);
      chk("flush hi kept", hi, 32'h0);
      chk("flush lo kept", lo, 32'h19);
      chk("flush divzero kept", W'(divzero), 0);

      // flush arriving in FIX (divide timing is fixed)
      issue(2'b11, 32'd100, 32'd7);
      repeat (33) @(posedge CLK);
      @(negedge CLK);
      flush = 1'b1;
      @(posedge CLK);
      #1 flush = 1'b0;
      count_done(10, nd);
      chk("fixflush no done", W'(nd), 0);
      chk("fixflush hi kept", hi, 32'h0);
      chk("fixflush lo kept", lo, 32'h19);
      chk("fixflush ready", W'(ready), 1);

      // unflushed rerun
      issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(cyc, got);
      chk("rerun done", W'(got), 1);
      chk("rerun hi", hi, 32'hFFFFFFFE);
      chk("rerun lo", lo, 32'h00000001);

      // flush and start together in IDLE
      @(negedge CLK);
      op    = 2'b01;
      portA = 32'd3;
      portB = 32'd3;
      start = 1'b1;
      flush = 1'b1;
      @(posedge CLK);
      #1;
      start = 1'b0;
      flush = 1'b0;
      chk("start+flush ready", W'(ready), 1);
      count_done(5, nd);
      chk("start+flush no done", W'(nd), 0);
      chk("start+flush lo kept", lo, 32'h00000001);

      // start held with new operands while busy
      @(negedge CLK);
      op    = 2'b11;
      portA = 32'd100;
      portB = 32'd7;
      start = 1'b1;
      @(posedge CLK);
      nd    = 0;
      first = 0;
      for (int c = 1; c <= 80; c++) begin
         @(negedge CLK);
         if (done) begin
            nd++;
            if (nd == 1) first = c;
         end
         if (c <= 34) begin
            op    = 2'b01;
            portA = W'(c);
            portB = 32'd3;
         end
         @(posedge CLK);
         if (c == 34) #1 start = 1'b0;
      end
      chk("held start done count", W'(nd), 1);
      chk("held start done cycle", W'(first), 35);
      chk("held start hi", hi, 32'd2);
      chk("held start lo", lo, 32'hE);

      // asynchronous reset mid-RUN
      issue(2'b11, 32'd5, 32'd0);
      wait_done(cyc, got);
      chk("pre-rst divzero", W'(divzero), 1);
      issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
      repeat (5) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      #1;
      chk("midrst ready", W'(ready), 1);
      chk("midrst busy", W'(busy), 0);
      chk("midrst done", W'(done), 0);
      chk("midrst divzero", W'(divzero), 0);
      chk("midrst hi", hi, 0);
      chk("midrst lo", lo, 0);
      @(negedge CLK);
      RST = 1'b0;
      issue(2'b01, 32'd2, 32'd3);
      wait_done(cyc, got);
      chk("post-rst done", W'(got), 1);
      chk("post-rst lo", lo, 32'd6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
